// File: rtl/batrider_snd_bridge.sv
// -----------------------------------------------------------------------------
// batrider_snd_bridge
// 68000-side endpoint of the main-CPU / Z80 sound mailbox (CLK96 domain).
//   - Writes to offsets 0/1 load SOUNDLATCH/SOUNDLATCH2 and emit a CS pulse
//     that raises the Z80 NMI. DTACK is stalled while the sound side holds
//     WAIT, up to TIMEOUT cycles.
//   - Reads return SOUNDLATCH3/4, a status byte, or 8'hFF.
//   - A synchronised rising edge of SNDIRQ latches a level-4 interrupt.
//
// Ports
//   CLK96        in   system clock
//   RESET96_N    in   asynchronous active-low reset
//   SND_SEL      in   decoded access to the sound window (whole bus cycle)
//   CPU_A[1:0]   in   word offset (68k A[2:1])
//   CPU_RW       in   1 = read
//   CPU_LDS_N    in   lower data strobe, active low
//   CPU_DIN[7:0] in   write data
//   CPU_DOUT     out  read data, captured at access start
//   DTACK_N      out  bus acknowledge, active low
//   IRQ4_N       out  level-4 interrupt request, active low
//   IACK         in   level-4 interrupt acknowledge strobe
//   SOUNDLATCH   out  command byte to the sound block
//   SOUNDLATCH2  out  second command byte to the sound block
//   CS           out  NMI-trigger pulse to the sound block
//   WAIT         in   sound side busy (NMI not yet cleared)
//   SNDIRQ       in   interrupt level from the Z80 side
//   SOUNDLATCH3  in   reply byte from the sound block
//   SOUNDLATCH4  in   second reply byte from the sound block
// -----------------------------------------------------------------------------
module batrider_snd_bridge #(
   parameter int CS_W    = 2,
   parameter int MIN_GAP = 4,
   parameter int TIMEOUT = 4096,
   parameter int STALL   = 1
) (
   input  logic       CLK96,
   input  logic       RESET96_N,
   input  logic       SND_SEL,
   input  logic [1:0] CPU_A,
   input  logic       CPU_RW,
   input  logic       CPU_LDS_N,
   input  logic [7:0] CPU_DIN,
   output logic [7:0] CPU_DOUT,
   output logic       DTACK_N,
   output logic       IRQ4_N,
   input  logic       IACK,
   output logic [7:0] SOUNDLATCH,
   output logic [7:0] SOUNDLATCH2,
   output logic       CS,
   input  logic       WAIT,
   input  logic       SNDIRQ,
   input  logic [7:0] SOUNDLATCH3,
   input  logic [7:0] SOUNDLATCH4
);

   localparam int CNT_W   = $clog2(CS_W + MIN_GAP + 1);
   localparam int STALL_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0]   LP_CS_END  = CNT_W'(CS_W);
   localparam logic [CNT_W-1:0]   LP_GAP_END = CNT_W'(MIN_GAP - 1);
   localparam logic [STALL_W-1:0] LP_TMO     = STALL_W'(TIMEOUT);

   typedef enum logic [2:0] {S_IDLE, S_PULSE, S_GAP, S_HOLD, S_ACK} t_state;

   t_state             r_state;
   t_state             w_state_nx;
   logic [CNT_W-1:0]   r_cnt;
   logic [STALL_W-1:0] r_stall;
   logic               r_acc_d;
   logic               r_abort;
   logic               r_cs;
   logic               r_dtack_n;
   logic [7:0]         r_dout;
   logic [7:0]         r_latch0;
   logic [7:0]         r_latch1;
   logic               r_irq_pend;
   logic               r_tmo_flag;
   logic [2:0]         r_sirq_sync;

   logic               w_acc;
   logic               w_start;
   logic               w_sirq_rise;
   logic [7:0]         w_rd_data;
   logic               w_lat0_we;
   logic               w_lat1_we;
   logic               w_cnt_clr;
   logic               w_stall_clr;
   logic               w_clr_flags;
   logic               w_tmo_set;
   logic               w_dtack_n_nx;

   assign w_acc       = SND_SEL & ~CPU_LDS_N;
   assign w_start     = w_acc & ~r_acc_d;
   assign w_sirq_rise = r_sirq_sync[1] & ~r_sirq_sync[2];

   always_comb begin
      case (CPU_A)
         2'd0:    w_rd_data = SOUNDLATCH3;
         2'd1:    w_rd_data = SOUNDLATCH4;
         2'd2:    w_rd_data = {WAIT, r_tmo_flag, 5'b0, r_irq_pend};
         default: w_rd_data = 8'hFF;
      endcase
   end

   always_ff @(posedge CLK96 or negedge RESET96_N) begin
      if (!RESET96_N) r_state <= S_IDLE;
      else            r_state <= w_state_nx;
   end

   // Next state plus single-cycle strobes. DTACK is asserted on the edge that
   // leaves GAP/HOLD so a latch write acks CS_W+MIN_GAP+2 cycles after the
   // access edge; reads pass through ACK once before DTACK drops.
   always_comb begin
      w_state_nx   = r_state;
      w_lat0_we    = 1'b0;
      w_lat1_we    = 1'b0;
      w_cnt_clr    = 1'b0;
      w_stall_clr  = 1'b0;
      w_clr_flags  = 1'b0;
      w_tmo_set    = 1'b0;
      w_dtack_n_nx = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               if (!CPU_RW && !CPU_A[1]) begin
                  w_lat0_we   = ~CPU_A[0];
                  w_lat1_we   = CPU_A[0];
                  w_cnt_clr   = 1'b1;
                  w_stall_clr = 1'b1;
                  w_state_nx  = S_PULSE;
               end else begin
                  w_clr_flags = ~CPU_RW & (CPU_A == 2'd3);
                  w_state_nx  = S_ACK;
               end
            end
         end
         S_PULSE: begin
            // The CS pulse always runs to completion, even on an aborted cycle.
            if (r_cnt == LP_CS_END) begin
               w_cnt_clr  = 1'b1;
               w_state_nx = (r_abort || !SND_SEL) ? S_IDLE : S_GAP;
            end
         end
         S_GAP: begin
            if (!SND_SEL) begin
               w_state_nx = S_IDLE;
            end else if (r_cnt == LP_GAP_END) begin
               if ((STALL == 0) || !WAIT) begin
                  w_dtack_n_nx = 1'b0;
                  w_state_nx   = S_ACK;
               end else begin
                  w_state_nx   = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (!SND_SEL) begin
               w_state_nx = S_IDLE;
            end else if (!WAIT) begin
               w_dtack_n_nx = 1'b0;
               w_state_nx   = S_ACK;
            end else if (r_stall >= LP_TMO) begin
               w_tmo_set    = 1'b1;
               w_dtack_n_nx = 1'b0;
               w_state_nx   = S_ACK;
            end
         end
         S_ACK: begin
            if (SND_SEL) w_dtack_n_nx = 1'b0;
            else         w_state_nx   = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK96 or negedge RESET96_N) begin
      if (!RESET96_N) begin
         r_acc_d     <= 1'b0;
         r_abort     <= 1'b0;
         r_cs        <= 1'b0;
         r_dtack_n   <= 1'b1;
         r_cnt       <= '0;
         r_stall     <= '0;
         r_dout      <= 8'h00;
         r_latch0    <= 8'h00;
         r_latch1    <= 8'h00;
         r_irq_pend  <= 1'b0;
         r_tmo_flag  <= 1'b0;
         r_sirq_sync <= 3'b000;
      end else begin
         r_acc_d     <= w_acc;
         r_dtack_n   <= w_dtack_n_nx;
         r_sirq_sync <= {r_sirq_sync[1:0], SNDIRQ};
         // CS rises one cycle after the latch loads, so data is stable on the edge.
         r_cs        <= (r_state == S_PULSE) && (r_cnt != LP_CS_END);
         r_abort     <= (r_state == S_PULSE) ? (r_abort | ~SND_SEL) : 1'b0;

         if (w_cnt_clr)
            r_cnt <= '0;
         else if (((r_state == S_PULSE) || (r_state == S_GAP)) && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_W'(1);

         // Stall counter starts counting on the CS rising edge and saturates.
         if (w_stall_clr)
            r_stall <= '0;
         else if (((r_state == S_PULSE) || (r_state == S_GAP) || (r_state == S_HOLD))
                  && (r_stall != '1))
            r_stall <= r_stall + STALL_W'(1);

         if (r_state == S_IDLE && w_start) r_dout <= w_rd_data;
         if (w_lat0_we) r_latch0 <= CPU_DIN;
         if (w_lat1_we) r_latch1 <= CPU_DIN;

         // A new SNDIRQ edge outranks a clear arriving in the same cycle.
         if (w_sirq_rise)               r_irq_pend <= 1'b1;
         else if (IACK || w_clr_flags)  r_irq_pend <= 1'b0;

         if (w_tmo_set)        r_tmo_flag <= 1'b1;
         else if (w_clr_flags) r_tmo_flag <= 1'b0;
      end
   end

   assign CPU_DOUT    = r_dout;
   assign DTACK_N     = r_dtack_n;
   assign IRQ4_N      = ~r_irq_pend;
   assign SOUNDLATCH  = r_latch0;
   assign SOUNDLATCH2 = r_latch1;
   assign CS          = r_cs;

endmodule

// File: tb/tb_batrider_snd_bridge.sv
module tb_batrider_snd_bridge;

   logic       CLK96;
   logic       RESET96_N;
   logic       SND_SEL;
   logic [1:0] CPU_A;
   logic       CPU_RW;
   logic       CPU_LDS_N;
   logic [7:0] CPU_DIN;
   logic [7:0] CPU_DOUT;
   logic       DTACK_N;
   logic       IRQ4_N;
   logic       IACK;
   logic [7:0] SOUNDLATCH;
   logic [7:0] SOUNDLATCH2;
   logic       CS;
   logic       WAIT;
   logic       SNDIRQ;
   logic [7:0] SOUNDLATCH3;
   logic [7:0] SOUNDLATCH4;

   int errs   = 0;
   int checks = 0;

   batrider_snd_bridge #(.CS_W(2), .MIN_GAP(4), .TIMEOUT(4096), .STALL(1)) dut (
      .CLK96(CLK96), .RESET96_N(RESET96_N), .SND_SEL(SND_SEL), .CPU_A(CPU_A),
      .CPU_RW(CPU_RW), .CPU_LDS_N(CPU_LDS_N), .CPU_DIN(CPU_DIN), .CPU_DOUT(CPU_DOUT),
      .DTACK_N(DTACK_N), .IRQ4_N(IRQ4_N), .IACK(IACK), .SOUNDLATCH(SOUNDLATCH),
      .SOUNDLATCH2(SOUNDLATCH2), .CS(CS), .WAIT(WAIT), .SNDIRQ(SNDIRQ),
      .SOUNDLATCH3(SOUNDLATCH3), .SOUNDLATCH4(SOUNDLATCH4)
   );

   initial CLK96 = 1'b0;
   always #5 CLK96 = ~CLK96;

   task automatic tick;
      @(posedge CLK96);
      #1;
   endtask

   task automatic bus_start(input logic [1:0] a, input logic rw, input logic [7:0] d);
      CPU_A     = a;
      CPU_RW    = rw;
      CPU_DIN   = d;
      SND_SEL   = 1'b1;
      CPU_LDS_N = 1'b0;
   endtask

   task automatic bus_release;
      SND_SEL   = 1'b0;
      CPU_LDS_N = 1'b1;
      tick;
      tick;
   endtask

   // Runs one access with the bus held; returns the cycle DTACK_N went low (0 = never).
   task automatic bus_cycle(input logic [1:0] a, input logic rw, input logic [7:0] d,
                            input int max_n, output int dt_n);
      bus_start(a, rw, d);
      dt_n = 0;
      for (int n = 1; n <= max_n; n++) begin
         tick;
         if (DTACK_N == 1'b0) begin
            dt_n = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      RESET96_N = 1'b0; SND_SEL = 1'b0; CPU_A = 2'd0; CPU_RW = 1'b1; CPU_LDS_N = 1'b1;
      CPU_DIN = 8'h00; IACK = 1'b0; WAIT = 1'b0; SNDIRQ = 1'b0;
      SOUNDLATCH3 = 8'h00; SOUNDLATCH4 = 8'h00;
      #23;
      checks++; if (CPU_DOUT !== 8'h00) begin errs++; $display("FAIL reset_dout: got %h want 00", CPU_DOUT); end
      checks++; if (DTACK_N !== 1'b1) begin errs++; $display("FAIL reset_dtack: got %b want 1", DTACK_N); end
      checks++; if (IRQ4_N !== 1'b1) begin errs++; $display("FAIL reset_irq: got %b want 1", IRQ4_N); end
      checks++; if (SOUNDLATCH !== 8'h00) begin errs++; $display("FAIL reset_sl: got %h want 00", SOUNDLATCH); end
      checks++; if (SOUNDLATCH2 !== 8'h00) begin errs++; $display("FAIL reset_sl2: got %h want 00", SOUNDLATCH2); end
      checks++; if (CS !== 1'b0) begin errs++; $display("FAIL reset_cs: got %b want 0", CS); end
      tick;
      RESET96_N = 1'b1;
      tick;
      tick;
   endtask

   task automatic test_latch_write;
      int cs_first = 0, cs_cnt = 0, dt_first = 0;
      WAIT = 1'b0;
      bus_start(2'd0, 1'b0, 8'h5A);
      for (int n = 1; n <= 12; n++) begin
         tick;
         if (n == 1) begin
            checks++; if (SOUNDLATCH !== 8'h5A) begin errs++; $display("FAIL lw_latch_early: got %h want 5a", SOUNDLATCH); end
            checks++; if (CS !== 1'b0) begin errs++; $display("FAIL lw_cs_early: got %b want 0", CS); end
         end
         if (CS === 1'b1) begin
            cs_cnt++;
            if (cs_first == 0) cs_first = n;
         end
         if (DTACK_N === 1'b0 && dt_first == 0) dt_first = n;
      end
      checks++; if (cs_first != 2) begin errs++; $display("FAIL lw_cs_rise: got cycle %0d want 2", cs_first); end
      checks++; if (cs_cnt != 2) begin errs++; $display("FAIL lw_cs_width: got %0d want 2", cs_cnt); end
      checks++; if (dt_first != 8) begin errs++; $display("FAIL lw_dtack: got cycle %0d want 8", dt_first); end
      SND_SEL = 1'b0; CPU_LDS_N = 1'b1;
      tick;
      checks++; if (DTACK_N !== 1'b1) begin errs++; $display("FAIL lw_dtack_release: got %b want 1", DTACK_N); end
      tick;
   endtask

   task automatic test_stall_write;
      int dt_first = 0;
      WAIT = 1'b0;
      bus_start(2'd1, 1'b0, 8'hC3);
      for (int n = 1; n <= 400; n++) begin
         tick;
         if (n == 3) WAIT = 1'b1;
         if (n == 303) WAIT = 1'b0;
         if (DTACK_N === 1'b0) begin
            dt_first = n;
            break;
         end
      end
      checks++; if (dt_first != 304) begin errs++; $display("FAIL stall_dtack: got cycle %0d want 304", dt_first); end
      checks++; if (SOUNDLATCH2 !== 8'hC3) begin errs++; $display("FAIL stall_sl2: got %h want c3", SOUNDLATCH2); end
      checks++; if (SOUNDLATCH !== 8'h5A) begin errs++; $display("FAIL stall_sl_kept: got %h want 5a", SOUNDLATCH); end
      bus_release;
      bus_cycle(2'd2, 1'b1, 8'h00, 6, dt_first);
      checks++; if (CPU_DOUT !== 8'h00) begin errs++; $display("FAIL stall_status: got %h want 00", CPU_DOUT); end
      bus_release;
   endtask

   task automatic test_timeout;
      int dt_n;
      WAIT = 1'b1;
      bus_cycle(2'd0, 1'b0, 8'h77, 5000, dt_n);
      checks++; if (dt_n != 4098) begin errs++; $display("FAIL tmo_dtack: got cycle %0d want 4098", dt_n); end
      checks++; if (SOUNDLATCH !== 8'h77) begin errs++; $display("FAIL tmo_sl: got %h want 77", SOUNDLATCH); end
      bus_release;
      bus_cycle(2'd2, 1'b1, 8'h00, 6, dt_n);
      checks++; if (CPU_DOUT !== 8'hC0) begin errs++; $display("FAIL tmo_status_set: got %h want c0", CPU_DOUT); end
      bus_release;
      bus_cycle(2'd3, 1'b0, 8'h00, 6, dt_n);
      checks++; if (dt_n != 2) begin errs++; $display("FAIL tmo_clr_dtack: got cycle %0d want 2", dt_n); end
      bus_release;
      bus_cycle(2'd2, 1'b1, 8'h00, 6, dt_n);
      checks++; if (CPU_DOUT !== 8'h80) begin errs++; $display("FAIL tmo_status_clr: got %h want 80", CPU_DOUT); end
      bus_release;
      WAIT = 1'b0;
      tick;
   endtask

   task automatic test_reads;
      int dt_n;
      SOUNDLATCH3 = 8'h11;
      SOUNDLATCH4 = 8'h22;
      bus_cycle(2'd0, 1'b1, 8'h00, 6, dt_n);
      checks++; if (CPU_DOUT !== 8'h11) begin errs++; $display("FAIL rd0_data: got %h want 11", CPU_DOUT); end
      checks++; if (dt_n != 2) begin errs++; $display("FAIL rd0_dtack: got cycle %0d want 2", dt_n); end
      bus_release;
      bus_cycle(2'd1, 1'b1, 8'h00, 6, dt_n);
      checks++; if (CPU_DOUT !== 8'h22) begin errs++; $display("FAIL rd1_data: got %h want 22", CPU_DOUT); end
      checks++; if (dt_n != 2) begin errs++; $display("FAIL rd1_dtack: got cycle %0d want 2", dt_n); end
      bus_release;
      bus_cycle(2'd3, 1'b1, 8'h00, 6, dt_n);
      checks++; if (CPU_DOUT !== 8'hFF) begin errs++; $display("FAIL rd3_data: got %h want ff", CPU_DOUT); end
      bus_release;
   endtask

   task automatic test_irq;
      int dt_n;
      SNDIRQ = 1'b1;
      tick;
      tick;
      checks++; if (IRQ4_N !== 1'b1) begin errs++; $display("FAIL irq_early: got %b want 1", IRQ4_N); end
      tick;
      checks++; if (IRQ4_N !== 1'b0) begin errs++; $display("FAIL irq_set: got %b want 0", IRQ4_N); end
      SNDIRQ = 1'b0;
      bus_cycle(2'd2, 1'b1, 8'h00, 6, dt_n);
      checks++; if (CPU_DOUT !== 8'h01) begin errs++; $display("FAIL irq_status: got %h want 01", CPU_DOUT); end
      bus_release;
      tick;
      SNDIRQ = 1'b1;
      tick;
      tick;
      IACK = 1'b1;
      tick;
      IACK = 1'b0;
      checks++; if (IRQ4_N !== 1'b0) begin errs++; $display("FAIL irq_set_wins: got %b want 0", IRQ4_N); end
      tick;
      checks++; if (IRQ4_N !== 1'b0) begin errs++; $display("FAIL irq_hold: got %b want 0", IRQ4_N); end
      IACK = 1'b1;
      tick;
      IACK = 1'b0;
      checks++; if (IRQ4_N !== 1'b1) begin errs++; $display("FAIL irq_iack_clr: got %b want 1", IRQ4_N); end
      SNDIRQ = 1'b0;
      tick;
   endtask

   task automatic test_abort;
      int cs_cnt = 0, dt_first = 0;
      WAIT = 1'b0;
      bus_start(2'd1, 1'b0, 8'hE7);
      for (int n = 1; n <= 12; n++) begin
         tick;
         if (n == 2) begin
            SND_SEL = 1'b0;
            CPU_LDS_N = 1'b1;
         end
         if (CS === 1'b1) cs_cnt++;
         if (DTACK_N === 1'b0 && dt_first == 0) dt_first = n;
      end
      checks++; if (cs_cnt != 2) begin errs++; $display("FAIL abort_cs_width: got %0d want 2", cs_cnt); end
      checks++; if (dt_first != 0) begin errs++; $display("FAIL abort_dtack: got cycle %0d want none", dt_first); end
      checks++; if (SOUNDLATCH2 !== 8'hE7) begin errs++; $display("FAIL abort_sl2: got %h want e7", SOUNDLATCH2); end
   endtask

   task automatic test_reset_mid;
      int dt_n;
      WAIT = 1'b0;
      bus_start(2'd0, 1'b0, 8'h3C);
      tick;
      tick;
      checks++; if (CS !== 1'b1) begin errs++; $display("FAIL rm_cs_before: got %b want 1", CS); end
      #2;
      RESET96_N = 1'b0;
      #1;
      checks++; if (CS !== 1'b0) begin errs++; $display("FAIL rm_cs: got %b want 0", CS); end
      checks++; if (DTACK_N !== 1'b1) begin errs++; $display("FAIL rm_dtack: got %b want 1", DTACK_N); end
      checks++; if (SOUNDLATCH !== 8'h00) begin errs++; $display("FAIL rm_sl: got %h want 00", SOUNDLATCH); end
      tick;
      SND_SEL = 1'b0;
      CPU_LDS_N = 1'b1;
      RESET96_N = 1'b1;
      tick;
      tick;
      bus_cycle(2'd0, 1'b0, 8'h96, 12, dt_n);
      checks++; if (dt_n != 8) begin errs++; $display("FAIL rm_fresh_dtack: got cycle %0d want 8", dt_n); end
      checks++; if (SOUNDLATCH !== 8'h96) begin errs++; $display("FAIL rm_fresh_sl: got %h want 96", SOUNDLATCH); end
      bus_release;
   endtask

   initial begin
      test_reset;
      test_latch_write;
      test_stall_write;
      test_timeout;
      test_reads;
      test_irq;
      test_abort;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/batrider_snd_bridge.md
Name: batrider_snd_bridge

Overview:
- 68000-side endpoint of the main-CPU/Z80 sound mailbox. Converts 68k bus cycles into writes of SOUNDLATCH/SOUNDLATCH2 and into the CS edge that raises the Z80 NMI.
- Stalls DTACK while the sound side holds WAIT. Returns SOUNDLATCH3/4 on reads.
- Turns the Z80 SNDIRQ strobe into a latched level-4 interrupt request.
- Sits between the main-CPU address decoder and the sound subsystem, all in the CLK96 domain.

Parameters:
- CS_W, 2: width of the CS high pulse, in CLK96 cycles (1..15).
- MIN_GAP, 4: cycles after CS falls before WAIT may be treated as released.
- TIMEOUT, 4096: maximum stall cycles before forced DTACK (≥ MIN_GAP+1).
- STALL, 1: 1 = hold DTACK on WAIT; 0 = ack writes immediately after the CS pulse.

Ports:
- CLK96, in, 1: system clock.
- RESET96_N, in, 1: asynchronous, active-low reset.
- SND_SEL, in, 1: decoded 68k access to the sound window, held for the whole bus cycle.
- CPU_A, in, 2: word offset (68k A[2:1]).
- CPU_RW, in, 1: 1 = read.
- CPU_LDS_N, in, 1: lower data strobe, active low. Only D[7:0] is used.
- CPU_DIN, in, 8: write data.
- CPU_DOUT, out, 8: read data.
- DTACK_N, out, 1: bus acknowledge.
- IRQ4_N, out, 1: interrupt request to the 68k.
- IACK, in, 1: interrupt-acknowledge strobe for level 4.
- SOUNDLATCH, out, 8: to the sound block.
- SOUNDLATCH2, out, 8: to the sound block.
- CS, out, 1: NMI-trigger edge to the sound block.
- WAIT, in, 1: sound side is busy (NMI not yet cleared).
- SNDIRQ, in, 1: level from the Z80 side.
- SOUNDLATCH3, in, 8: from the sound block.
- SOUNDLATCH4, in, 8: from the sound block.

Behaviour:
- Reset values: CPU_DOUT=0, DTACK_N=1, IRQ4_N=1, SOUNDLATCH=0, SOUNDLATCH2=0, CS=0. Internal state: FSM=IDLE, irq_pend=0, tmo_flag=0, all counters 0.
- Access start: a new access is the rising edge of (SND_SEL & !CPU_LDS_N), registered. Further accesses are ignored until the FSM returns to IDLE.
- Register map:
  - Write offset 0 → SOUNDLATCH.
  - Write offset 1 → SOUNDLATCH2.
  - Write offset 2 → no effect.
  - Write offset 3 → clears irq_pend and tmo_flag; data ignored.
  - Read offset 0 → SOUNDLATCH3.
  - Read offset 1 → SOUNDLATCH4.
  - Read offset 2 → {WAIT, tmo_flag, 5'b0, irq_pend}.
  - Read offset 3 → 8'hFF.
- CPU_DOUT is registered at access start and held until the next access.
- FSM states:
  - IDLE: on a write to offset 0/1, latch the data, set CS=1, load the counter → PULSE. On any other access → ACK one cycle later.
  - PULSE: CS stays high for CS_W cycles, then CS=0 → GAP.
  - GAP: count MIN_GAP cycles → HOLD. If STALL=0 → ACK directly.
  - HOLD: leave when WAIT==0 → ACK. If the stall counter (started at CS rise) reaches TIMEOUT first, set tmo_flag=1 → ACK.
  - ACK: DTACK_N=0 until SND_SEL==0, then DTACK_N=1 → IDLE.
- Latency: a read or non-latch write gets DTACK_N low 2 cycles after the access edge. A latch write with WAIT already low acks after CS_W+MIN_GAP+2 cycles.
- The latch value updates in the IDLE→PULSE transition cycle, i.e. before CS rises, so the sound side sees the data stable on the CS edge.
- Interrupt path:
  - SNDIRQ is synchronised with 2 flops; a rising edge sets irq_pend.
  - IRQ4_N = !irq_pend.
  - IACK or a write to offset 3 clears irq_pend.
  - Simultaneous set and clear in one cycle: set wins.
- Bus cycle aborted: if SND_SEL falls during PULSE/GAP/HOLD, the FSM still completes the CS pulse, goes to IDLE without asserting DTACK, and keeps the latch value.
- Counter widths: clog2(TIMEOUT+1) for the stall counter; counters saturate and never wrap.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously), CS included.

Test Plan:
- Write offset 0 data 8'h5A, WAIT tied 0 → SOUNDLATCH=8'h5A before CS rises; CS high exactly 2 cycles; DTACK_N low at cycle 8 after the access edge and high one cycle after SND_SEL drops.
- Write offset 1 data 8'hC3, WAIT rises 1 cycle after CS and falls 300 cycles later → DTACK_N stays high until the cycle after WAIT falls; SOUNDLATCH2=8'hC3; SOUNDLATCH unchanged; tmo_flag=0.
- Write offset 0, WAIT held 1 forever → forced DTACK at stall count 4096; read offset 2 returns 8'hC0; after a write to offset 3, read offset 2 returns 8'h80 (WAIT still 1).
- SOUNDLATCH3=8'h11, SOUNDLATCH4=8'h22; read offsets 0 then 1 → CPU_DOUT 8'h11 then 8'h22, each DTACK at 2 cycles; read offset 3 → 8'hFF.
- SNDIRQ pulse → IRQ4_N=0 three cycles later. IACK in the same cycle as a second synchronised SNDIRQ edge → IRQ4_N stays 0. A further IACK → IRQ4_N=1.
- RESET96_N pulsed low during PULSE → CS=0 and DTACK_N=1 immediately; SOUNDLATCH=0. After release, a fresh write completes normally.
